// File: rtl/ex_mem_pipe_stage_if.sv
// ----------------------------------------------------------------------------
// ex_mem_pipe_stage_if
// Bundles every EX->MEM pipeline-register signal except clk/rst so the stage
// and its environment connect through a single port.
//
// Modports
//   slave  : the pipeline stage itself (consumes *E, ReadyM, FlushM; drives
//            ReadyE and the *M head outputs plus CountM)
//   master : the surrounding EX/MEM logic (drives *E, ReadyM, FlushM)
//
// Signal summary
//   FlushM                      discard all held entries
//   ValidE / ReadyE             EX-side handshake
//   ALUResultE RdE WriteDataE   EX-side data payload
//   PCPlus4E                    EX-side PC+4
//   RegWriteE MemWriteE         EX-side write enables
//   ResultSrcE Funct3E          EX-side control payload
//   ValidM / ReadyM             MEM-side handshake
//   *M                          head entry payload (write enables gated)
//   CountM                      entries currently held (0..2)
// ----------------------------------------------------------------------------
interface ex_mem_pipe_stage_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int RESULT_SRC_W   = 2
);
   logic                      FlushM;

   logic                      ValidE;
   logic                      ReadyE;
   logic [DATA_WIDTH-1:0]     ALUResultE;
   logic [REG_ADDR_WIDTH-1:0] RdE;
   logic [DATA_WIDTH-1:0]     WriteDataE;
   logic [DATA_WIDTH-1:0]     PCPlus4E;
   logic                      RegWriteE;
   logic                      MemWriteE;
   logic [RESULT_SRC_W-1:0]   ResultSrcE;
   logic [2:0]                Funct3E;

   logic                      ValidM;
   logic                      ReadyM;
   logic [DATA_WIDTH-1:0]     ALUResultM;
   logic [REG_ADDR_WIDTH-1:0] RdM;
   logic [DATA_WIDTH-1:0]     WriteDataM;
   logic [DATA_WIDTH-1:0]     PCPlus4M;
   logic                      RegWriteM;
   logic                      MemWriteM;
   logic [RESULT_SRC_W-1:0]   ResultSrcM;
   logic [2:0]                Funct3M;
   logic [1:0]                CountM;

   modport slave (
      input  FlushM,
      input  ValidE, ALUResultE, RdE, WriteDataE, PCPlus4E,
      input  RegWriteE, MemWriteE, ResultSrcE, Funct3E,
      output ReadyE,
      output ValidM, ALUResultM, RdM, WriteDataM, PCPlus4M,
      output RegWriteM, MemWriteM, ResultSrcM, Funct3M, CountM,
      input  ReadyM
   );

   modport master (
      output FlushM,
      output ValidE, ALUResultE, RdE, WriteDataE, PCPlus4E,
      output RegWriteE, MemWriteE, ResultSrcE, Funct3E,
      input  ReadyE,
      input  ValidM, ALUResultM, RdM, WriteDataM, PCPlus4M,
      input  RegWriteM, MemWriteM, ResultSrcM, Funct3M, CountM,
      output ReadyM
   );
endinterface

// File: rtl/ex_mem_pipe_stage.sv
// ----------------------------------------------------------------------------
// ex_mem_pipe_stage
// Elastic EX->MEM pipeline register. Holds the ALU result, Rd, store data,
// PC+4 and MEM/WB control bits under a valid/ready handshake, with flush
// (bubble insertion) and optional skid buffering.
//
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : ex_mem_pipe_stage_if.slave (EX handshake + payload in,
//          MEM handshake + head payload out, FlushM, CountM)
//
// Configuration macro
//   EXMEM_SKID_EN defined   : two-entry stage (head + skid). ReadyE depends
//                             only on registered state, so MEM stalls never
//                             ripple combinationally back into EX.
//   EXMEM_SKID_EN undefined : single-entry stage; ReadyE = !ValidM | ReadyM.
// ----------------------------------------------------------------------------
module ex_mem_pipe_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int RESULT_SRC_W   = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   ex_mem_pipe_stage_if.slave      bus
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0]     alu_result;
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic [DATA_WIDTH-1:0]     write_data;
      logic [DATA_WIDTH-1:0]     pc_plus4;
      logic                      reg_write;
      logic                      mem_write;
      logic [RESULT_SRC_W-1:0]   result_src;
      logic [2:0]                funct3;
   } entry_t;

`ifdef EXMEM_SKID_EN
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_t;
`else
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;
`endif

   state_t state_q, state_d;
   entry_t head_q,  head_d;
`ifdef EXMEM_SKID_EN
   entry_t skid_q,  skid_d;
`endif

   entry_t in_entry;
   logic   ready_e;
   logic   valid_m;
   logic   accept;
   logic   advance;

   assign in_entry = '{
      alu_result: bus.ALUResultE,
      rd:         bus.RdE,
      write_data: bus.WriteDataE,
      pc_plus4:   bus.PCPlus4E,
      reg_write:  bus.RegWriteE,
      mem_write:  bus.MemWriteE,
      result_src: bus.ResultSrcE,
      funct3:     bus.Funct3E
   };

   assign valid_m = (state_q != ST_EMPTY);

   // ReadyE is forced low during reset so nothing is accepted until the
   // stage is known to be empty.
`ifdef EXMEM_SKID_EN
   assign ready_e = !rst && (state_q != ST_SKID);
`else
   assign ready_e = !rst && (!valid_m || bus.ReadyM);
`endif

   assign accept  = bus.ValidE && ready_e;
   assign advance = valid_m && bus.ReadyM;

   // ---------------------------------------------------------------------
   // Next-state / next-payload
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_d = state_q;
      head_d  = head_q;
`ifdef EXMEM_SKID_EN
      skid_d  = skid_q;
`endif

      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d = ST_FULL;
               head_d  = in_entry;
            end
         end
         ST_FULL: begin
            if (accept && advance) begin
               head_d  = in_entry;
            end else if (advance) begin
               state_d = ST_EMPTY;
`ifdef EXMEM_SKID_EN
            end else if (accept) begin
               // MEM stalled but EX already saw ReadyE=1: park it in skid.
               state_d = ST_SKID;
               skid_d  = in_entry;
`endif
            end
         end
`ifdef EXMEM_SKID_EN
         ST_SKID: begin
            if (advance) begin
               state_d = ST_FULL;
               head_d  = skid_q;
            end
         end
`endif
         default: state_d = ST_EMPTY;
      endcase

      // Flush wins over accept/advance; any entry accepted now is dropped.
      if (bus.FlushM) begin
         state_d = ST_EMPTY;
      end
   end

   // ---------------------------------------------------------------------
   // State and payload registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      if (rst) begin
         // NOTE: payload registers are reset too, because the head payload
         // drives the *M outputs directly and must read zero out of reset.
         state_q <= ST_EMPTY;
         head_q  <= '0;
`ifdef EXMEM_SKID_EN
         skid_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
`ifdef EXMEM_SKID_EN
         skid_q  <= skid_d;
`endif
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign bus.ReadyE     = ready_e;
   assign bus.ValidM     = valid_m;
   assign bus.ALUResultM = head_q.alu_result;
   assign bus.RdM        = head_q.rd;
   assign bus.WriteDataM = head_q.write_data;
   assign bus.PCPlus4M   = head_q.pc_plus4;
   assign bus.ResultSrcM = head_q.result_src;
   assign bus.Funct3M    = head_q.funct3;
   // Bubbles (and stale payload after a flush) must never write RF/memory.
   assign bus.RegWriteM  = head_q.reg_write && valid_m;
   assign bus.MemWriteM  = head_q.mem_write && valid_m;

`ifdef EXMEM_SKID_EN
   assign bus.CountM = (state_q == ST_SKID) ? 2'd2 :
                       (state_q == ST_FULL) ? 2'd1 : 2'd0;
`else
   assign bus.CountM = {1'b0, (state_q == ST_FULL)};
`endif

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_mem_pipe_stage
// Self-checking bench for ex_mem_pipe_stage. A queue model tracks the
// entries held by the stage; every cycle the head payload, ValidM, CountM,
// ReadyE and write-enable gating are compared against it. Works with and
// without EXMEM_SKID_EN.
// ----------------------------------------------------------------------------
module tb_ex_mem_pipe_stage;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int RW = 2;

   typedef struct packed {
      logic [DW-1:0] alu_result;
      logic [AW-1:0] rd;
      logic [DW-1:0] write_data;
      logic [DW-1:0] pc_plus4;
      logic          reg_write;
      logic          mem_write;
      logic [RW-1:0] result_src;
      logic [2:0]    funct3;
   } exp_t;

   typedef struct {
      bit            valid_e;
      bit            flush;
      logic [DW-1:0] alu;
      bit            exp_valid;
      logic [DW-1:0] exp_alu;
   } vec_t;

   logic clk;
   logic rst;

   ex_mem_pipe_stage_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .RESULT_SRC_W(RW)) bus ();

   ex_mem_pipe_stage #(
      .DATA_WIDTH    (DW),
      .REG_ADDR_WIDTH(AW),
      .RESULT_SRC_W  (RW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   errors = 0;
   int   checks = 0;
   exp_t sb_q[$];
   exp_t cur_entry;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t make_entry(input logic [DW-1:0] alu);
      exp_t e;
      e.alu_result = alu;
      e.rd         = alu[4:0] ^ 5'h15;
      e.write_data = alu ^ 32'hA5A5_0F0F;
      e.pc_plus4   = alu + 32'd4;
      e.reg_write  = alu[4];
      e.mem_write  = alu[5];
      e.result_src = alu[3:2];
      e.funct3     = alu[6:4];
      return e;
   endfunction

   task automatic drive(input bit valid_e, input logic [DW-1:0] alu, input bit ready_m, input bit flush);
      cur_entry      = make_entry(alu);
      bus.ValidE     = valid_e;
      bus.ALUResultE = cur_entry.alu_result;
      bus.RdE        = cur_entry.rd;
      bus.WriteDataE = cur_entry.write_data;
      bus.PCPlus4E   = cur_entry.pc_plus4;
      bus.RegWriteE  = cur_entry.reg_write;
      bus.MemWriteE  = cur_entry.mem_write;
      bus.ResultSrcE = cur_entry.result_src;
      bus.Funct3E    = cur_entry.funct3;
      bus.ReadyM     = ready_m;
      bus.FlushM     = flush;
   endtask

   // Called shortly after a falling edge with inputs already driven.
   // Compares outputs with the model, then advances the model one edge.
   task automatic step();
      bit ready_exp;
      bit accept;
      bit advance;
      #1;
`ifdef EXMEM_SKID_EN
      ready_exp = (sb_q.size() < 2);
`else
      ready_exp = (sb_q.size() == 0) || bus.ReadyM;
`endif
      check("ReadyE", 64'(bus.ReadyE), 64'(ready_exp));
      check("CountM", 64'(bus.CountM), 64'(sb_q.size()));
      check("ValidM", 64'(bus.ValidM), 64'(sb_q.size() != 0));
      if (sb_q.size() != 0) begin
         check("ALUResultM", 64'(bus.ALUResultM), 64'(sb_q[0].alu_result));
         check("RdM",        64'(bus.RdM),        64'(sb_q[0].rd));
         check("WriteDataM", 64'(bus.WriteDataM), 64'(sb_q[0].write_data));
         check("PCPlus4M",   64'(bus.PCPlus4M),   64'(sb_q[0].pc_plus4));
         check("ResultSrcM", 64'(bus.ResultSrcM), 64'(sb_q[0].result_src));
         check("Funct3M",    64'(bus.Funct3M),    64'(sb_q[0].funct3));
         check("RegWriteM",  64'(bus.RegWriteM),  64'(sb_q[0].reg_write));
         check("MemWriteM",  64'(bus.MemWriteM),  64'(sb_q[0].mem_write));
      end else begin
         check("RegWriteM_bubble", 64'(bus.RegWriteM), 64'd0);
         check("MemWriteM_bubble", 64'(bus.MemWriteM), 64'd0);
      end
      accept  = bus.ValidE && ready_exp;
      advance = (sb_q.size() != 0) && bus.ReadyM;
      @(posedge clk);
      if (bus.FlushM) begin
         sb_q.delete();
      end else begin
         if (advance) void'(sb_q.pop_front());
         if (accept)  sb_q.push_back(cur_entry);
      end
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   vec_t vecs[9];

   initial begin
      // Streaming table with ReadyM held high; identical in both builds.
      vecs[0] = '{1'b1, 1'b0, 32'h10, 1'b0, 32'h0};
      vecs[1] = '{1'b1, 1'b0, 32'h20, 1'b1, 32'h10};
      vecs[2] = '{1'b1, 1'b0, 32'h30, 1'b1, 32'h20};
      vecs[3] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h30};
      vecs[4] = '{1'b1, 1'b0, 32'h40, 1'b0, 32'h0};
      vecs[5] = '{1'b1, 1'b1, 32'h50, 1'b1, 32'h40};
      vecs[6] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
      vecs[7] = '{1'b1, 1'b1, 32'h60, 1'b0, 32'h0};
      vecs[8] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0};

      // ---------------- Reset: two cycles with ValidE high -------------
      rst = 1'b1;
      drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_ValidM",     64'(bus.ValidM),     64'd0);
      check("rst_CountM",     64'(bus.CountM),     64'd0);
      check("rst_ReadyE",     64'(bus.ReadyE),     64'd0);
      check("rst_ALUResultM", 64'(bus.ALUResultM), 64'd0);
      check("rst_RdM",        64'(bus.RdM),        64'd0);
      check("rst_WriteDataM", 64'(bus.WriteDataM), 64'd0);
      check("rst_PCPlus4M",   64'(bus.PCPlus4M),   64'd0);
      check("rst_ResultSrcM", 64'(bus.ResultSrcM), 64'd0);
      check("rst_Funct3M",    64'(bus.Funct3M),    64'd0);
      check("rst_RegWriteM",  64'(bus.RegWriteM),  64'd0);
      check("rst_MemWriteM",  64'(bus.MemWriteM),  64'd0);
      rst = 1'b0;
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      #1;
      check("rel_ReadyE", 64'(bus.ReadyE), 64'd1);
      @(negedge clk);

      // ---------------- Table-driven stream -----------------------------
      for (int i = 0; i < 9; i++) begin
         drive(vecs[i].valid_e, vecs[i].alu, 1'b1, vecs[i].flush);
         #1;
         check($sformatf("tbl%0d_ValidM", i), 64'(bus.ValidM), 64'(vecs[i].exp_valid));
         if (vecs[i].exp_valid)
            check($sformatf("tbl%0d_ALUResultM", i), 64'(bus.ALUResultM), 64'(vecs[i].exp_alu));
         step();
      end

      // ---------------- Stall / skid build-up ---------------------------
      drive(1'b1, 32'hA, 1'b0, 1'b0); step();
      drive(1'b1, 32'hB, 1'b0, 1'b0); step();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
`ifdef EXMEM_SKID_EN
      #1;
      check("skid_CountM", 64'(bus.CountM),     64'd2);
      check("skid_ReadyE", 64'(bus.ReadyE),     64'd0);
      check("skid_head",   64'(bus.ALUResultM), 64'hA);
`endif
      step();
      repeat (3) begin
         drive(1'b0, 32'h0, 1'b1, 1'b0); step();
      end

      // ---------------- Flush with an accept in the same cycle ----------
      drive(1'b1, 32'hD, 1'b0, 1'b0); step();
      drive(1'b1, 32'hE, 1'b0, 1'b0); step();
      drive(1'b1, 32'hC, 1'b0, 1'b1); step();
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      #1;
      check("flush_ValidM",    64'(bus.ValidM),    64'd0);
      check("flush_CountM",    64'(bus.CountM),    64'd0);
      check("flush_MemWriteM", 64'(bus.MemWriteM), 64'd0);
      step();
      step();

      // ---------------- Write-enable gating ------------------------------
      drive(1'b1, 32'h30, 1'b0, 1'b0); step();
      repeat (2) begin
         drive(1'b0, 32'h0, 1'b0, 1'b0);
         #1;
         check("gate_MemWriteM_held", 64'(bus.MemWriteM), 64'd1);
         check("gate_RegWriteM_held", 64'(bus.RegWriteM), 64'd1);
         step();
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0); step();
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      #1;
      check("gate_MemWriteM_after", 64'(bus.MemWriteM), 64'd0);
      check("gate_RegWriteM_after", 64'(bus.RegWriteM), 64'd0);
      step();

`ifndef EXMEM_SKID_EN
      // ---------------- Combinational ReadyE (single-entry build) -------
      drive(1'b1, 32'h55, 1'b0, 1'b0); step();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      #1;
      check("comb_ReadyE_stall", 64'(bus.ReadyE), 64'd0);
      bus.ReadyM = 1'b1;
      #1;
      check("comb_ReadyE_go", 64'(bus.ReadyE), 64'd1);
      step();
`endif

      // ---------------- Random traffic -----------------------------------
      for (int i = 0; i < 300; i++) begin
         drive(($urandom % 4) != 0, DW'($urandom), ($urandom % 3) != 0, ($urandom % 16) == 0);
         step();
      end
      repeat (3) begin
         drive(1'b0, 32'h0, 1'b1, 1'b0); step();
      end

      // ---------------- Reset and flush together ------------------------
      drive(1'b1, 32'h77, 1'b0, 1'b0); step();
      rst = 1'b1;
      drive(1'b1, 32'h99, 1'b0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      #1;
      check("rstflush_ValidM",     64'(bus.ValidM),     64'd0);
      check("rstflush_CountM",     64'(bus.CountM),     64'd0);
      check("rstflush_ALUResultM", 64'(bus.ALUResultM), 64'd0);
      check("rstflush_PCPlus4M",   64'(bus.PCPlus4M),   64'd0);
      sb_q.delete();
      rst = 1'b0;
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
